sum_accumulator: RTL and testbench

- Downstream consumer of the 16-bit adder stage. Takes one adder sum per cycle and accumulates a programmable-length burst of sums into a wider accumulator.
- Presents the total on a valid/ready output handshake.
- Sits between the adder pipeline and the result sink (register readback / next datapath stage).

---
 rtl/accum_pkg.sv | 17 +
 rtl/burst_counter.sv | 39 +++
 rtl/sum_accumulator.sv | 120 ++++++++++++
 tb/tb_sum_accumulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and default widths for the sum accumulator slice.
// Holds the burst FSM state encoding and the width constants.
package accum_pkg;

    // Burst state machine encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Default widths: incoming adder sum, accumulator, burst length.
    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int LEN_W_DEF  = 8;

endpackage

// File: rtl/burst_counter.sv
// Loadable down-counter tracking samples left in the current burst.
// Ports: clk, rst (sync, active-high), load/load_val, dec -> count, last.
module burst_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic [LEN_W-1:0] count,
    output logic             last
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LEN_W'(1));

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a programmable-length burst of adder sums into a wider
// register and offers the total on a valid/ready output handshake.
// Ports: clk, rst (sync, active-high); start/len open a burst;
//        sum_in/sum_valid carry samples; acc_out/acc_valid/acc_ready
//        deliver the total; busy flags ACCUM/HOLD; overflow is a sticky
//        per-burst carry-out flag. All outputs are registered.
// ACC_W must be >= DATA_W.
module sum_accumulator
    import accum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] sum_in,
    input  logic              sum_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic              overflow
);

    // Zero padding that lifts sum_in to ACC_W+1 bits (one extra for carry).
    localparam int PAD = ACC_W + 1 - DATA_W;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic             ov_q;
    logic             valid_q;
    logic             busy_q;

    logic [ACC_W:0]   add_d;
    logic [LEN_W-1:0] rem;
    logic             rem_last;
    logic             cnt_load;
    logic             cnt_dec;

    // Unsigned add with the carry kept in the top bit.
    assign add_d = {1'b0, acc_q} + {{PAD{1'b0}}, sum_in};

    assign cnt_load = (state_q == IDLE) && start && (len != '0);
    assign cnt_dec  = (state_q == ACCUM) && sum_valid;

    burst_counter #(
        .LEN_W    (LEN_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (len),
        .dec      (cnt_dec),
        .count    (rem),
        .last     (rem_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ov_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q  <= '0;
                        ov_q   <= 1'b0;
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            // Empty burst: result 0 is ready at once.
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (rem == '0) begin
                        // Unreachable in normal flow; never strand the FSM.
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                    end else if (sum_valid) begin
                        acc_q <= add_d[ACC_W-1:0];
                        ov_q  <= ov_q | add_d[ACC_W];
                        if (rem_last) begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // acc_q is left untouched until the next start.
                    if (acc_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign acc_out   = acc_q;
    assign acc_valid = valid_q;
    assign busy      = busy_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator at ACC_W=24 and ACC_W=17.
// Both instances share stimulus; expected totals come from plain sums.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [15:0] sum_in;
    logic        sum_valid;
    logic        acc_ready;

    logic [23:0] acc_out;
    logic        acc_valid;
    logic        busy;
    logic        overflow;

    logic [16:0] acc_out17;
    logic        acc_valid17;
    logic        busy17;
    logic        overflow17;

    always #5 clk = ~clk;

    sum_accumulator #(
        .DATA_W    (16),
        .ACC_W     (24),
        .LEN_W     (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    sum_accumulator #(
        .DATA_W    (16),
        .ACC_W     (17),
        .LEN_W     (8)
    ) u_dut17 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .acc_out   (acc_out17),
        .acc_valid (acc_valid17),
        .acc_ready (acc_ready),
        .busy      (busy17),
        .overflow  (overflow17)
    );

    typedef struct {
        logic [23:0] a24;
        logic        o24;
        logic [16:0] a17;
        logic        o17;
    } exp_t;

    exp_t exp_q[$];
    int   smp[$];
    int   stl[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string name, input longint act,
                       input longint req);
        checks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation when a result appears, then holds it
    // while acc_valid stays high so backpressure stability is checked too.
    exp_t cur;
    bit   have = 1'b0;

    always @(negedge clk) begin
        if (!rst && (acc_valid || acc_valid17)) begin
            if (!have) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", acc_valid, 0);
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1'b1;
                end
            end
            if (have) begin
                chk("acc_out24", acc_out, cur.a24);
                chk("overflow24", overflow, cur.o24);
                chk("acc_out17", acc_out17, cur.a17);
                chk("overflow17", overflow17, cur.o17);
                chk("valid24", acc_valid, 1);
                chk("valid17", acc_valid17, 1);
                chk("busy_hold", busy, 1);
                if (acc_ready) have = 1'b0;
            end
        end
    end

    // One burst of n samples from smp[] with stl[] idle cycles before
    // each; bp cycles of backpressure before the result is taken.
    task automatic burst(input int n, input int bp);
        longint tot;
        exp_t   e;
        tot = 0;
        for (int i = 0; i < n; i++) tot += longint'(smp[i]);
        e.a24 = 24'(tot % (64'd1 << 24));
        e.o24 = (tot >= (64'd1 << 24));
        e.a17 = 17'(tot % (64'd1 << 17));
        e.o17 = (tot >= (64'd1 << 17));
        exp_q.push_back(e);

        @(posedge clk); #1;
        start     = 1'b1;
        len       = 8'(n);
        sum_valid = 1'b1;
        sum_in    = 16'($urandom);
        acc_ready = 1'b0;
        @(posedge clk); #1;
        start     = 1'b0;
        sum_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (stl[i]) begin
                sum_valid = 1'b0;
                sum_in    = 16'($urandom);
                start     = 1'($urandom_range(0, 1));
                len       = 8'($urandom);
                @(posedge clk); #1;
            end
            sum_valid = 1'b1;
            sum_in    = 16'(smp[i]);
            start     = 1'($urandom_range(0, 1));
            len       = 8'($urandom);
            @(posedge clk); #1;
        end
        sum_valid = 1'b0;
        start     = 1'b0;
        repeat (bp) begin
            start     = 1'($urandom_range(0, 1));
            len       = 8'($urandom);
            sum_valid = 1'($urandom_range(0, 1));
            sum_in    = 16'($urandom);
            @(posedge clk); #1;
        end
        acc_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd5;
        sum_valid = 1'b0;
        @(posedge clk); #1;
        acc_ready = 1'b0;
        start     = 1'b0;
        chk("busy_after_ack", busy, 0);
        chk("busy17_after_ack", busy17, 0);
        chk("valid_after_ack", acc_valid, 0);
        chk("acc_kept_after_ack", acc_out, e.a24);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        sum_in    = '0;
        sum_valid = 1'b0;
        acc_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc_out", acc_out, 0);
        chk("rst_valid", acc_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;

        smp = '{10, 20, 30, 40};
        stl = '{0, 0, 0, 0};
        burst(4, 0);

        smp = '{'hFFFF, 'hFFFF, 1};
        stl = '{0, 2, 0};
        burst(3, 0);

        smp = {};
        stl = {};
        for (int i = 0; i < 255; i++) begin
            smp.push_back('hFFFF);
            stl.push_back(0);
        end
        burst(255, 0);
        burst(2, 0);
        burst(3, 0);

        smp = '{5, 6};
        stl = '{0, 0};
        burst(2, 5);

        burst(0, 2);

        // Reset after 2 of 4 samples: burst discarded, no result.
        @(posedge clk); #1;
        start = 1'b1;
        len   = 8'd4;
        @(posedge clk); #1;
        start     = 1'b0;
        sum_valid = 1'b1;
        sum_in    = 16'd100;
        @(posedge clk); #1;
        sum_in = 16'd200;
        @(posedge clk); #1;
        sum_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", acc_valid, 0);
        chk("mid_rst_acc", acc_out, 0);
        chk("mid_rst_ovf", overflow, 0);

        smp = '{7};
        stl = '{0};
        burst(1, 0);

        repeat (25) begin
            int n;
            n   = $urandom_range(0, 12);
            smp = {};
            stl = {};
            for (int i = 0; i < n; i++) begin
                smp.push_back(int'($urandom_range(0, 65535)));
                stl.push_back(int'($urandom_range(0, 2)));
            end
            burst(n, int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
